// File: rtl/eq_seq_ctrl.sv
// Sequential W-bit equality checker: one shared 2-bit eq2 slice is stepped
// across the latched operands, LSB pair first, stopping at the first mismatch.
module eq_seq_ctrl #(
    parameter int W  = 8,
    parameter int CW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done_tick,
    output logic         aeqb
);

    localparam int P = W / 2;

    typedef enum logic [1:0] {
        idle = 2'd0,
        cmp  = 2'd1,
        done = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    sa;
    logic [W-1:0]    sb;
    logic [CW-1:0]   cnt;
    logic            res;
    logic            e;

    eq2 u_eq2 (
        .a    (sa[1:0]),
        .b    (sb[1:0]),
        .aeqb (e)
    );

    // One pair per cycle; a mismatching pair ends the compare immediately,
    // so the remaining upper pairs are never shifted down.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= idle;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            res   <= 1'b0;
        end else begin
            case (state)
                idle: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= CW'(P - 1);
                        res   <= 1'b0;
                        state <= cmp;
                    end
                end
                cmp: begin
                    if (!e) begin
                        res   <= 1'b0;
                        state <= done;
                    end else if (cnt == '0) begin
                        res   <= 1'b1;
                        state <= done;
                    end else begin
                        sa    <= sa >> 2;
                        sb    <= sb >> 2;
                        cnt   <= cnt - 1'b1;
                    end
                end
                done: begin
                    state <= idle;
                end
                default: begin
                    state <= idle;
                end
            endcase
        end
    end

    assign ready     = (state == idle);
    assign busy      = (state == cmp);
    assign done_tick = (state == done);
    assign aeqb      = res;

endmodule

// 2-bit equality slice in sum-of-products form.
module eq2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       aeqb
);

    logic p0;
    logic p1;
    logic p2;
    logic p3;

    assign p0   = ~a[1] & ~b[1] & ~a[0] & ~b[0];
    assign p1   = ~a[1] & ~b[1] &  a[0] &  b[0];
    assign p2   =  a[1] &  b[1] & ~a[0] & ~b[0];
    assign p3   =  a[1] &  b[1] &  a[0] &  b[0];
    assign aeqb = p0 | p1 | p2 | p3;

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// Directed self-checking bench for eq_seq_ctrl (W=8, P=4); status is
// compared per cycle as {ready, busy, done_tick, aeqb}.
module tb_eq_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done_tick;
    logic       aeqb;
    logic [3:0] st;

    int n_cmp  = 0;
    int n_fail = 0;

    eq_seq_ctrl #(.W(8), .CW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .busy      (busy),
        .done_tick (done_tick),
        .aeqb      (aeqb)
    );

    assign st = {ready, busy, done_tick, aeqb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; afterwards we sit 1 time unit into the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns in cycle 1.
    task automatic do_accept(input logic [7:0] av, input logic [7:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (st !== 4'b1000) begin
                n_fail++;
                $display("[TB] FAIL reset_hold cyc%0d: status=%b want=1000", k, st);
            end
        end
        start = 1'b0;
        reset = 1'b0;
        step();
        n_cmp++;
        if (st !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_release: status=%b want=1000", st);
        end
    endtask

    task automatic test_equal();
        logic [3:0] exp;
        do_accept(8'hA5, 8'hA5);
        for (int k = 1; k <= 6; k++) begin
            exp = (k < 5) ? 4'b0100 : (k == 5) ? 4'b0011 : 4'b1001;
            n_cmp++;
            if (st !== exp) begin
                n_fail++;
                $display("[TB] FAIL equal_A5 cyc%0d: status=%b want=%b", k, st, exp);
            end
            step();
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (st !== 4'b1001) begin
                n_fail++;
                $display("[TB] FAIL equal_hold idle%0d: status=%b want=1001", k, st);
            end
            step();
        end
    endtask

    task automatic test_msb_mismatch();
        logic [3:0] exp;
        do_accept(8'h35, 8'hF5);
        for (int k = 1; k <= 6; k++) begin
            exp = (k < 5) ? 4'b0100 : (k == 5) ? 4'b0010 : 4'b1000;
            n_cmp++;
            if (st !== exp) begin
                n_fail++;
                $display("[TB] FAIL msb_mismatch cyc%0d: status=%b want=%b", k, st, exp);
            end
            step();
        end
    endtask

    task automatic test_lsb_mismatch();
        logic [3:0] exp;
        do_accept(8'h01, 8'h02);
        for (int k = 1; k <= 3; k++) begin
            exp = (k < 2) ? 4'b0100 : (k == 2) ? 4'b0010 : 4'b1000;
            n_cmp++;
            if (st !== exp) begin
                n_fail++;
                $display("[TB] FAIL lsb_mismatch cyc%0d: status=%b want=%b", k, st, exp);
            end
            step();
        end
    endtask

    task automatic test_ignored_start();
        int ticks;
        int tick_cyc;
        ticks    = 0;
        tick_cyc = 0;
        do_accept(8'h3C, 8'h3C);
        for (int k = 1; k <= 12; k++) begin
            if (done_tick === 1'b1) begin
                ticks++;
                tick_cyc = k;
                n_cmp++;
                if (aeqb !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL ignored_start_result: aeqb=%b want=1", aeqb);
                end
            end
            if (k <= 4) begin
                a = 8'(k * 37);
                b = 8'(k * 91);
            end
            start = (k == 2);
            if (k == 2) a = 8'h00;
            step();
        end
        start = 1'b0;
        n_cmp++;
        if (ticks !== 1 || tick_cyc !== 5) begin
            n_fail++;
            $display("[TB] FAIL ignored_start_ticks: count=%0d at cyc%0d want 1 at cyc5", ticks, tick_cyc);
        end
        n_cmp++;
        if (st !== 4'b1001) begin
            n_fail++;
            $display("[TB] FAIL ignored_start_idle: status=%b want=1001", st);
        end
    endtask

    task automatic test_reset_mid();
        int ticks;
        logic [3:0] exp;
        ticks = 0;
        do_accept(8'hFF, 8'hFF);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if (st !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL reset_mid cyc3: status=%b want=1000", st);
        end
        for (int k = 0; k < 8; k++) begin
            if (done_tick === 1'b1) ticks++;
            step();
        end
        n_cmp++;
        if (ticks !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_no_tick: ticks=%0d want=0", ticks);
        end
        do_accept(8'h12, 8'h12);
        for (int k = 1; k <= 6; k++) begin
            exp = (k < 5) ? 4'b0100 : (k == 5) ? 4'b0011 : 4'b1001;
            n_cmp++;
            if (st !== exp) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_recover cyc%0d: status=%b want=%b", k, st, exp);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        a     = 8'h00;
        b     = 8'h00;
        start = 1'b1;
        step();
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) b = 8'h80;
            if (k == 11) start = 1'b0;
            if (k <= 4 || (k >= 7 && k <= 10)) exp = 4'b0100;
            else if (k == 5)  exp = 4'b0011;
            else if (k == 6)  exp = 4'b1001;
            else if (k == 11) exp = 4'b0010;
            else              exp = 4'b1000;
            n_cmp++;
            if (st !== exp) begin
                n_fail++;
                $display("[TB] FAIL back_to_back cyc%0d: status=%b want=%b", k, st, exp);
            end
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        test_reset();
        test_equal();
        test_msb_mismatch();
        test_lsb_mismatch();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eq_seq_ctrl.md
# eq_seq_ctrl

Sequential W-bit equality checker that time-shares a single `eq2` 2-bit comparator slice across a wide operand pair, two bits per cycle, LSB pair first. It sits between a requester and one shared `eq2` instance. It latches both operands on a start handshake, steps the slice through every bit pair, terminates early on the first mismatching pair, and reports a held result with a one-cycle completion tick.

## Interface
- `W`, default 8: operand width. Must be even and ≥ 2. Number of pairs is `P = W/2`.
- `CW`, default 2: pair-counter width. Must satisfy `2^CW ≥ P`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high. It is sampled only on the `clk` rising edge.
- `start` in 1: request to compare `a` and `b`. It is honoured only while `ready=1`.
- `a` in W: operand A. It is sampled on the edge where `start` is accepted.
- `b` in W: operand B. It is sampled on the same edge as `a`.
- `ready` out 1: high in `idle` only. It is a combinational decode of the state register.
- `busy` out 1: high in `cmp` only.
- `done_tick` out 1: one-cycle pulse, high in `done` only.
- `aeqb` out 1: result register. 1 means the last completed compare found `a == b`. It is held until the next accepted start.

## Operation
- Internal registers:
  - `sa`, `sb`: W-bit shift registers.
  - `cnt`: CW-bit pair counter.
  - `res`: drives `aeqb`.
  - `state`: one of `{idle, cmp, done}`.
- One `eq2` instance compares `sa[1:0]` with `sb[1:0]`. Its output is `e`.
- `idle`:
  - On `start=1`: load `sa<=a`, `sb<=b`, `cnt<=P-1`, `res<=0`, then go to `cmp`.
  - Otherwise stay in `idle`. All registers hold.
- `cmp`, one pair is evaluated per cycle:
  - `e=0`: `res<=0`, go to `done` (early termination). The remaining pairs are not examined.
  - `e=1` and `cnt==0`: `res<=1`, go to `done`.
  - `e=1` and `cnt!=0`: `sa<=sa>>2`, `sb<=sb>>2`, `cnt<=cnt-1`, stay in `cmp`.
- `done`: `done_tick=1` for exactly this cycle, then go unconditionally to `idle`.
- `start` is ignored in `cmp` and `done`. No queuing: a request raised while not ready is lost unless it is still asserted in `idle`.
- `aeqb` is cleared at accept. It is valid from the `done_tick` cycle onward and is held through `idle` until the next accept.
- `a` and `b` may change freely after the accept edge. The compare uses only the latched copies.
- Reset in any state forces the following on the next edge, overriding every other condition including a simultaneous `start`:
  - `state<=idle`
  - `sa<=0`, `sb<=0`
  - `cnt<=0`
  - `res<=0`
- Reset values of outputs: `ready=1`, `busy=0`, `done_tick=0`, `aeqb=0`.

## Timing
- Edge 0 accepts `start`. Cycle k is the cycle after edge k-1.
- Equal operands:
  - `busy` is high in cycles 1..P.
  - `done_tick` is high in cycle P+1, with `aeqb=1`.
  - `ready` returns in cycle P+2.
  - Total latency from accept to `done_tick` is P+1 cycles.
- First mismatch at pair j, where pair j is bits `[2j+1:2j]` and j is 0-based:
  - `done_tick` is high in cycle j+2, with `aeqb=0`.
  - Minimum latency is 2 cycles (j=0). Maximum is P+1 cycles (j=P-1).
- Back-to-back operation: `start` held high continuously is accepted in the first `idle` cycle after `done`. The minimum accept-to-accept spacing is therefore latency + 1.
- `W=2` (P=1): `cmp` lasts exactly one cycle. `done_tick` is in cycle 2 for both outcomes.
- `start` and `reset` high on the same edge: reset wins. The block stays in `idle` and `aeqb` stays 0.

## Test plan
- Reset: hold `reset` 2 cycles with `start=1` → `ready=1`, `busy=0`, `done_tick=0`, `aeqb=0`; no transition to `cmp`.
- Equal, W=8: accept `a=b=8'hA5` → `busy` in cycles 1–4, `done_tick` in cycle 5 with `aeqb=1`, `ready` in cycle 6; `aeqb` stays 1 for 10 idle cycles.
- MSB-pair mismatch: `a=8'h35`, `b=8'hF5` (pair 3 differs) → `done_tick` in cycle 5, `aeqb=0`. LSB mismatch: `a=8'h01`, `b=8'h02` → `done_tick` in cycle 2, `aeqb=0`.
- Ignored start and operand change: accept `a=b=8'h3C`; pulse `start` in cycle 2 with `a=8'h00`; change `a`/`b` every cycle while busy → exactly one `done_tick` (cycle 5), `aeqb=1`, no second compare.
- Reset mid-operation: accept `a=b=8'hFF`, assert `reset` at the cycle-2 edge → cycle 3 `ready=1`, `busy=0`, `aeqb=0`, no `done_tick` ever; new accept of `8'h12`/`8'h12` completes normally with `aeqb=1`.
- Back-to-back: `start` held high, first pair `8'h00`/`8'h00`, then `8'h00`/`8'h80` → `done_tick` in cycles 5 (`aeqb=1`) and 11 (`aeqb=0`).
